dms_encoder_tx: RTL and testbench

//  Transmit end of the DMS serial link: drives the single-wire str/mode pair read by the DMS decryption receiver.
//  A configuration phase (mode=1) shifts out key width n, key d and mask capsN.
//  A data phase (mode=0) sends message bits as fixed-length run-length symbols.
//  The receiver recovers each bit by ones/zeros majority and delimits symbols on the first 0->1 edge.

---
 rtl/dms_tx_pkg.sv | 26 ++
 rtl/dms_sym_gen.sv | 44 ++++
 rtl/dms_encoder_tx.sv | 149 ++++++++++++++
 tb/tb_dms_encoder_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dms_tx_pkg.sv
// Shared types and constants for the DMS serial link transmitter.
// State encoding, key-width limit, default symbol timing, index helper.
package dms_tx_pkg;

  localparam int N_MAX       = 5;
  localparam int SYM_LEN_DEF = 16;
  localparam int MAJ_LEN_DEF = 11;
  localparam int IDX_W       = 6;
  localparam int ST_W        = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE,
    CFG_N,
    CFG_D,
    CFG_C,
    PRE,
    SYM,
    TAIL
  } state_t;

  // Index of the top key bit, 2**n-1 (n is already range-checked).
  function automatic logic [IDX_W-1:0] key_top(input logic [3:0] n);
    return (IDX_W'(1) << n) - IDX_W'(1);
  endfunction

endpackage

// File: rtl/dms_sym_gen.sv
// Run-length symbol generator: sample counter plus latched bit.
// Ports: clk, reset, run, load, sym_bit in; str_sym, last out.
module dms_sym_gen
  import dms_tx_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int MAJ_LEN = MAJ_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic load,
  input  logic sym_bit,
  output logic str_sym,
  output logic last
);

  localparam int CW = $clog2(SYM_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(SYM_LEN - 1);
  localparam logic [CW-1:0] ONES_1   = CW'(MAJ_LEN);
  localparam logic [CW-1:0] ONES_0   = CW'(SYM_LEN - MAJ_LEN);

  logic [CW-1:0] cnt;
  logic          bit_q;
  logic [CW-1:0] ones;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      bit_q <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      bit_q <= sym_bit;
    end else if (run) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

  // Leading ones, trailing zeros: every symbol opens with a 0->1 edge.
  assign ones    = bit_q ? ONES_1 : ONES_0;
  assign str_sym = (cnt < ones);
  assign last    = (cnt == LAST_CNT);

endmodule

// File: rtl/dms_encoder_tx.sv
// DMS link transmitter: config shift-out (mode=1) then run-length data.
// Ports: cfg_start/n/d/capsn, data valid/bit/ready, str, mode, busy, cfg_err.
module dms_encoder_tx
  import dms_tx_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int MAJ_LEN = MAJ_LEN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [3:0]  cfg_n,
  input  logic [31:0] cfg_d,
  input  logic [31:0] cfg_capsn,
  input  logic        data_valid,
  input  logic        data_bit,
  output logic        data_ready,
  output logic        str,
  output logic        mode,
  output logic        busy,
  output logic        cfg_err
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [3:0]         n_q;
  logic [31:0]        d_q;
  logic [31:0]        c_q;
  logic               err_q, err_n;
  logic               latch;
  logic               load;
  logic               sym_bit;
  logic               run;
  logic               str_sym;
  logic               last;

  assign run = (state == PRE) || (state == SYM);

  dms_sym_gen #(
    .SYM_LEN (SYM_LEN),
    .MAJ_LEN (MAJ_LEN)
  ) u_sym (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .load    (load),
    .sym_bit (sym_bit),
    .str_sym (str_sym),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      n_q   <= '0;
      d_q   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      err_q <= err_n;
      if (latch) begin
        n_q <= cfg_n;
        d_q <= cfg_d;
        c_q <= cfg_capsn;
      end
    end
  end

  assign err_n = (state == IDLE) && cfg_start
              && (cfg_n > 4'(N_MAX));

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    latch      = 1'b0;
    load       = 1'b0;
    sym_bit    = 1'b0;
    str        = 1'b0;
    mode       = 1'b0;
    data_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start && (cfg_n <= 4'(N_MAX))) begin
          state_n = CFG_N;
          idx_n   = IDX_W'(3);
          latch   = 1'b1;
        end
      end
      CFG_N: begin
        mode = 1'b1;
        str  = n_q[idx[1:0]];
        if (idx == '0) begin
          state_n = CFG_D;
          idx_n   = key_top(n_q);
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      CFG_D: begin
        mode = 1'b1;
        str  = d_q[idx[4:0]];
        if (idx == '0) begin
          state_n = CFG_C;
          idx_n   = key_top(n_q);
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      CFG_C: begin
        mode = 1'b1;
        str  = c_q[idx[4:0]];
        if (idx == '0) begin
          // Preamble is a throwaway bit-0 symbol.
          state_n = PRE;
          load    = 1'b1;
          sym_bit = 1'b0;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      PRE, SYM: begin
        str = str_sym;
        if (last) begin
          data_ready = 1'b1;
          if (data_valid) begin
            state_n = SYM;
            load    = 1'b1;
            sym_bit = data_bit;
          end else begin
            state_n = TAIL;
          end
        end
      end
      TAIL: begin
        // Single high sample closes the last frame at the receiver.
        str     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign cfg_err = err_q;

endmodule

// File: tb/tb_dms_encoder_tx.sv
// Scoreboard bench for dms_encoder_tx.
// Per-cycle expected {busy,mode,str,data_ready,cfg_err} queue.
module tb_dms_encoder_tx;

  localparam int SL = 16;
  localparam int ML = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [3:0]  cfg_n = '0;
  logic [31:0] cfg_d = '0;
  logic [31:0] cfg_capsn = '0;
  logic        data_valid = 1'b0;
  logic        data_bit = 1'b0;
  logic        data_ready;
  logic        str;
  logic        mode;
  logic        busy;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;
  int rdy_cnt = 0;

  logic [4:0] sb[$];
  bit         msg_q[$];

  dms_encoder_tx #(
    .SYM_LEN (SL),
    .MAJ_LEN (ML)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_n      (cfg_n),
    .cfg_d      (cfg_d),
    .cfg_capsn  (cfg_capsn),
    .data_valid (data_valid),
    .data_bit   (data_bit),
    .data_ready (data_ready),
    .str        (str),
    .mode       (mode),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (data_ready === 1'b1) rdy_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("line", {27'd0, busy, mode, str, data_ready, cfg_err},
          {27'd0, e});
    end
  end

  always @(posedge clk) begin
    if (data_valid && data_ready && msg_q.size() > 0)
      void'(msg_q.pop_front());
    #1;
    data_valid = (msg_q.size() > 0);
    data_bit   = (msg_q.size() > 0) ? msg_q[0] : 1'b0;
  end

  task automatic push_sym(input bit b);
    for (int i = 0; i < SL; i++) begin
      bit s;
      s = b ? (i < ML) : (i < SL - ML);
      sb.push_back({1'b1, 1'b0, s, (i == SL - 1), 1'b0});
    end
  endtask

  task automatic start_tx(input logic [3:0] n,
                          input logic [31:0] d,
                          input logic [31:0] c,
                          input bit msgs[$]);
    int w;
    @(posedge clk);
    #1;
    cfg_n     = n;
    cfg_d     = d;
    cfg_capsn = c;
    cfg_start = 1'b1;
    w = 1 << n;
    sb.push_back(5'b00000);
    for (int i = 3; i >= 0; i--)
      sb.push_back({2'b11, n[i], 2'b00});
    for (int i = w - 1; i >= 0; i--)
      sb.push_back({2'b11, d[i], 2'b00});
    for (int i = w - 1; i >= 0; i--)
      sb.push_back({2'b11, c[i], 2'b00});
    push_sym(1'b0);
    foreach (msgs[k]) push_sym(msgs[k]);
    sb.push_back(5'b10100);
    sb.push_back(5'b00000);
    msg_q = msgs;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic hit_reset(input string tag);
    reset = 1'b1;
    sb.delete();
    msg_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(tag, {29'd0, busy, mode, str}, 32'd0);
  endtask

  initial begin
    bit m[$];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {27'd0, busy, mode, str, data_ready, cfg_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: n=2 config, empty message
    m = {};
    start_tx(4'd2, 32'hA, 32'h3, m);
    drain();

    // 2: n=5, message 1,0,1
    m = {1'b1, 1'b0, 1'b1};
    start_tx(4'd5, 32'hDEADBEEF, 32'h0F0F1234, m);
    drain();

    // 3: single bit then valid drops
    rdy_cnt = 0;
    m = {1'b1};
    start_tx(4'd3, 32'h96, 32'h5C, m);
    drain();
    chk("ready_count", rdy_cnt, 2);

    // 4: illegal key width
    @(posedge clk);
    #1;
    cfg_n     = 4'd6;
    cfg_start = 1'b1;
    sb.push_back(5'b00000);
    sb.push_back(5'b00001);
    sb.push_back(5'b00000);
    sb.push_back(5'b00000);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    drain();

    // 5: reset mid CFG_D and mid SYM
    m = {};
    start_tx(4'd3, 32'h5A, 32'hC3, m);
    repeat (6) @(posedge clk);
    #1;
    hit_reset("rst_cfg_d");
    m = {1'b1, 1'b1, 1'b1};
    start_tx(4'd0, 32'h1, 32'h0, m);
    repeat (28) @(posedge clk);
    #1;
    hit_reset("rst_sym");
    m = {1'b0};
    start_tx(4'd2, 32'hA, 32'h3, m);
    drain();

    // reset and cfg_start together
    @(posedge clk);
    #1;
    cfg_n     = 4'd1;
    cfg_start = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("rst_vs_start", {29'd0, busy, mode, str}, 32'd0);

    // 6: cfg_start re-pulsed while busy
    m = {1'b1, 1'b0, 1'b1};
    start_tx(4'd1, 32'h2, 32'h1, m);
    repeat (30) @(posedge clk);
    #1;
    cfg_n     = 4'd6;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_n     = 4'd4;
    cfg_d     = 32'hFFFF;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
